processor: RTL and testbench

- Trace-driven processor model and request master for the two-level cache hierarchy.
- Replays a fixed program of 8 byte-wide memory accesses (reads and writes, 24-bit address) towards the L1 cache, one request at a time.
- Each request is completed by the cache's RDY handshake.
- Used as the traffic source in cache-hierarchy integration benches.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/processor_prog_rom.sv | 24 ++
 rtl/processor.sv | 79 +++++++
 tb/tb_processor.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types for the processor traffic source and the cache hierarchy it drives.
// Holds the bus widths, the request encoding and the sequencer states.
package cache_pkg;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 8;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic {
        ISSUE = 1'b0,
        DONE  = 1'b1
    } state_e;

endpackage

// File: rtl/processor_prog_rom.sv
// Fixed access program replayed by the processor model.
// Entries 0-2 exercise write, read-hit, then a same-index/different-tag conflict.
module processor_prog_rom
    import cache_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output req_t             req
);

    always_comb begin
        req = '{op: OP_RD, addr: '0, wdata: '0};
        case (idx)
            3'd0:    req = '{op: OP_WR, addr: 24'h000010, wdata: 8'hA5};
            3'd1:    req = '{op: OP_RD, addr: 24'h000010, wdata: 8'h00};
            3'd2:    req = '{op: OP_WR, addr: 24'h001010, wdata: 8'h3C};
            3'd3:    req = '{op: OP_RD, addr: 24'h000010, wdata: 8'h00};
            3'd4:    req = '{op: OP_RD, addr: 24'h001010, wdata: 8'h00};
            3'd5:    req = '{op: OP_WR, addr: 24'hFFFFF0, wdata: 8'h7E};
            3'd6:    req = '{op: OP_RD, addr: 24'hFFFFF0, wdata: 8'h00};
            default: req = '{op: OP_RD, addr: 24'h123456, wdata: 8'h00};
        endcase
    end

endmodule

// File: rtl/processor.sv
// Trace-driven request master: replays the program ROM one request at a time,
// advancing on each RDY completion, then parks idle with done raised.
module processor
    import cache_pkg::*;
#(
    parameter int ADDR_W  = cache_pkg::ADDR_W,
    parameter int DATA_W  = cache_pkg::DATA_W,
    parameter int NUM_REQ = cache_pkg::NUM_REQ
) (
    input  logic              clk,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] data_in,
    output logic              read,
    output logic              write,
    input  logic              RDY,
    input  logic              rst,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_e            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    req_t              req;

    processor_prog_rom u_rom (
        .idx (idx_reg),
        .req (req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ISSUE;
            idx_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            rdata_reg <= rdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        rdata_next = rdata_reg;
        addr       = '0;
        data_out   = '0;
        read       = 1'b0;
        write      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ISSUE: begin
                addr     = ADDR_W'(req.addr);
                read     = (req.op == OP_RD);
                write    = (req.op == OP_WR);
                data_out = (req.op == OP_WR) ? DATA_W'(req.wdata) : '0;
                if (RDY) begin
                    if (req.op == OP_RD)
                        rdata_next = data_in;
                    // The next entry is presented straight from the completing edge.
                    if (idx_reg == LAST_IDX)
                        state_next = DONE;
                    else
                        idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                done = 1'b1;
            end
        endcase
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed scenarios plus random RDY/reset
// traffic, compared against a program-level reference model.
module tb_processor;

    logic        clk = 1'b0;
    logic        rst;
    logic        RDY;
    logic [7:0]  data_in;
    logic [23:0] addr;
    logic [7:0]  data_out;
    logic        read;
    logic        write;
    logic        done;
    logic [7:0]  rdata;

    int n_vec = 0;
    int n_err = 0;

    // Reference program, written out as the access trace.
    bit          p_wr   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [23:0] p_addr [8] = '{24'h000010, 24'h000010, 24'h001010, 24'h000010,
                                24'h001010, 24'hFFFFF0, 24'hFFFFF0, 24'h123456};
    logic [7:0]  p_wd   [8] = '{8'hA5, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h7E, 8'h00, 8'h00};

    int         m_idx;
    bit         m_done;
    logic [7:0] m_rdata;

    processor dut (
        .clk      (clk),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .read     (read),
        .write    (write),
        .RDY      (RDY),
        .rst      (rst),
        .done     (done),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [42:0] exp_vec();
        if (m_done)
            return {24'h0, 8'h0, 1'b0, 1'b0, 1'b1, m_rdata};
        return {p_addr[m_idx], p_wr[m_idx] ? p_wd[m_idx] : 8'h00,
                !p_wr[m_idx], p_wr[m_idx], 1'b0, m_rdata};
    endfunction

    function automatic logic [42:0] act_vec();
        return {addr, data_out, read, write, done, rdata};
    endfunction

    // One clock: drive inputs, advance the model on the edge, settle on negedge.
    task automatic tick(input logic r, input logic rdy, input logic [7:0] din);
        rst = r; RDY = rdy; data_in = din;
        @(posedge clk);
        if (r) begin
            m_idx = 0; m_done = 0; m_rdata = 8'h00;
        end else if (!m_done && rdy) begin
            if (!p_wr[m_idx]) m_rdata = din;
            if (m_idx == 7) m_done = 1;
            else m_idx++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 8'($urandom));
        tick(1'b1, 1'b0, 8'($urandom));
        n_vec++;
        if ({write, read, addr, data_out, done, rdata} !== {1'b1, 1'b0, 24'h000010, 8'hA5, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state got w=%b r=%b addr=%h dout=%h done=%b rdata=%h need w=1 r=0 addr=000010 dout=a5 done=0 rdata=00",
                     write, read, addr, data_out, done, rdata);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 8'($urandom));
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_hold[%0d] got %h need %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_pulse_sequence();
        logic [23:0] seq [8] = '{24'h000010, 24'h000010, 24'h001010, 24'h000010,
                                 24'h001010, 24'hFFFFF0, 24'hFFFFF0, 24'h123456};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (addr !== seq[k] || act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL pulse_entry[%0d] got addr=%h vec=%h need addr=%h vec=%h",
                         k, addr, act_vec(), seq[k], exp_vec());
            end
            tick(1'b0, 1'b1, 8'($urandom));
            tick(1'b0, 1'b0, 8'($urandom));
        end
        n_vec++;
        if ({done, read, write, addr} !== {1'b1, 1'b0, 1'b0, 24'h0} || act_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL pulse_done got done=%b r=%b w=%b addr=%h need done=1 r=0 w=0 addr=000000",
                     done, read, write, addr);
        end
    endtask

    task automatic test_read_capture();
        do_reset();
        tick(1'b0, 1'b1, 8'($urandom));
        n_vec++;
        if ({read, addr} !== {1'b1, 24'h000010}) begin
            n_err++;
            $display("FAIL capture_entry1 got r=%b addr=%h need r=1 addr=000010", read, addr);
        end
        tick(1'b0, 1'b1, 8'h5A);
        n_vec++;
        if (rdata !== 8'h5A) begin
            n_err++;
            $display("FAIL capture_read got rdata=%h need 5a", rdata);
        end
        tick(1'b0, 1'b1, 8'h99);
        n_vec++;
        if (rdata !== 8'h5A || act_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL capture_write_keeps got rdata=%h vec=%h need rdata=5a vec=%h",
                     rdata, act_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1, 8'($urandom));
            n_vec++;
            if (done !== (k == 7) || act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL b2b[%0d] got done=%b vec=%h need done=%0d vec=%h",
                         k, done, act_vec(), (k == 7), exp_vec());
            end
        end
    endtask

    task automatic test_after_done();
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'($urandom), 8'($urandom));
            n_vec++;
            if ({done, read, write, addr, data_out} !== {1'b1, 1'b0, 1'b0, 24'h0, 8'h0} ||
                act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL after_done[%0d] got %h need %h", k, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 8'($urandom));
        tick(1'b1, 1'b1, 8'($urandom));
        n_vec++;
        if ({write, addr, data_out, rdata, done} !== {1'b1, 24'h000010, 8'hA5, 8'h00, 1'b0} ||
            act_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL mid_reset got w=%b addr=%h dout=%h rdata=%h done=%b need w=1 addr=000010 dout=a5 rdata=00 done=0",
                     write, addr, data_out, rdata, done);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom));
            n_vec++;
            if (act_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d] got %h need %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; RDY = 1'b0; data_in = 8'h00;
        m_idx = 0; m_done = 0; m_rdata = 8'h00;
        test_reset();
        test_pulse_sequence();
        test_read_capture();
        test_back_to_back();
        test_after_done();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
